iterative_divider: RTL and testbench



---
 rtl/iterative_divider.sv | 180 ++++++++++++++++++
 tb/tb_iterative_divider.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/iterative_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU; result valid N+1 edges after accept (optional DIV_ZERO_FAST_EN shortcut for /0).
// Valid/ready on both sides: accepts only in IDLE, holds result in DONE until ready_i.

module ripple_carry_adder_Nb #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         inv_b_i,
  input  logic         carry_i,
  output logic [N-1:0] sum_o,
  output logic         carry_o
);
  // inv_b_i selects subtraction: b is inverted and the +1 of two's complement is injected
  // on the carry chain, so carry_o=1 means a >= b when carry_i=0.
  logic [N:0]   c;
  logic [N-1:0] b_eff;

  assign b_eff = b_i ^ {N{inv_b_i}};
  assign c[0]  = carry_i ^ inv_b_i;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_eff[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_eff[i]) | (c[i] & (a_i[i] ^ b_eff[i]));
  end

  assign carry_o = c[N];
endmodule

module iterative_divider #(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  input  logic         signed_i,
  input  logic         rem_sel_i,
  output logic         valid_o,
  output logic [N-1:0] result_o,
  input  logic         ready_i
);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t state, state_next;

  logic [N-1:0]  dvs;       // divisor magnitude
  logic [N-1:0]  quo;       // dividend bits shift out of the top, quotient bits shift in at the bottom
  logic [N-1:0]  rem;       // partial remainder
  logic [CW-1:0] cnt;
  logic          signed_q;
  logic          rem_sel_q;
  logic          q_neg;
  logic          r_neg;

  logic          dividend_neg;
  logic          divisor_neg;
  logic [N-1:0]  dividend_abs;
  logic [N-1:0]  divisor_abs;

  logic [N:0]    shifted;
  logic [N:0]    diff;
  logic          no_borrow;
  logic [N-1:0]  quo_fixed;
  logic [N-1:0]  rem_fixed;

  always_comb begin
    dividend_neg = signed_i & dividend_i[N-1];
    divisor_neg  = signed_i & divisor_i[N-1];
    dividend_abs = dividend_neg ? (~dividend_i + 1'b1) : dividend_i;
    divisor_abs  = divisor_neg  ? (~divisor_i + 1'b1)  : divisor_i;
  end

  assign shifted = {rem, quo[N-1]};

  ripple_carry_adder_Nb #(.N(N + 1)) u_sub (
    .a_i     (shifted),
    .b_i     ({1'b0, dvs}),
    .inv_b_i (1'b1),
    .carry_i (1'b0),
    .sum_o   (diff),
    .carry_o (no_borrow)
  );

  always_comb begin
    quo_fixed = (signed_q & q_neg) ? (~quo + 1'b1) : quo;
    rem_fixed = (signed_q & r_neg) ? (~rem + 1'b1) : rem;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready_o    = 1'b0;
    valid_o    = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
`ifdef DIV_ZERO_FAST_EN
          state_next = (divisor_i == '0) ? FIX : BUSY;
`else
          state_next = BUSY;
`endif
        end
      end
      BUSY: begin
        if (cnt == '0) state_next = FIX;
      end
      FIX: state_next = DONE;
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dvs       <= '0;
      quo       <= '0;
      rem       <= '0;
      cnt       <= '0;
      signed_q  <= 1'b0;
      rem_sel_q <= 1'b0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      result_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            dvs       <= divisor_abs;
            rem       <= '0;
            cnt       <= CW'(N - 1);
            signed_q  <= signed_i;
            rem_sel_q <= rem_sel_i;
            // A zero divisor keeps the all-ones quotient unsigned-looking, as RV32M requires.
            q_neg     <= (dividend_neg ^ divisor_neg) & (divisor_i != '0);
            r_neg     <= dividend_neg;
`ifdef DIV_ZERO_FAST_EN
            if (divisor_i == '0) begin
              quo <= '1;
              rem <= dividend_abs;
            end else begin
              quo <= dividend_abs;
            end
`else
            quo <= dividend_abs;
`endif
          end
        end
        BUSY: begin
          if (no_borrow) begin
            rem <= diff[N-1:0];
          end else begin
            rem <= shifted[N-1:0];
          end
          quo <= {quo[N-2:0], no_borrow};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          result_o <= rem_sel_q ? rem_fixed : quo_fixed;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_iterative_divider.sv
// Directed bench for iterative_divider: RV32M corner cases, latency, back-pressure, mid-operation reset.
`timescale 1ns/1ps

module tb_iterative_divider;
  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        sgn;
  logic        rem_sel;
  logic        valid_out;
  logic [31:0] result;
  logic        ready_in;

  int errors = 0;
  int checks = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 33;
`endif

  iterative_divider #(.N(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .valid_i    (valid_in),
    .ready_o    (ready_out),
    .dividend_i (dividend),
    .divisor_i  (divisor),
    .signed_i   (sgn),
    .rem_sel_i  (rem_sel),
    .valid_o    (valid_out),
    .result_o   (result),
    .ready_i    (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one operation from IDLE, returns the result and accept-to-valid edge count (-1 on timeout).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic r,
                        output logic [31:0] res, output int lat);
    dividend = a;
    divisor  = b;
    sgn      = s;
    rem_sel  = r;
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    lat = 0;
    while (valid_out !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    if (valid_out !== 1'b1) lat = -1;
    res = result;
    ready_in = 1'b1;
    @(posedge clk);
    #1 ready_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b exp=1", ready_out); end
  endtask

  task automatic test_unsigned();
    logic [31:0] res;
    int lat;
    run_op(32'd100, 32'd7, 1'b0, 1'b0, res, lat);
    checks++; if (res !== 32'h0000000E) begin errors++; $display("FAIL divu_100_7 got=%h exp=0000000e", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency got=%0d exp=33", lat); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL retire_ready got=%b exp=1", ready_out); end
    run_op(32'd100, 32'd7, 1'b0, 1'b1, res, lat);
    checks++; if (res !== 32'h00000002) begin errors++; $display("FAIL remu_100_7 got=%h exp=00000002", res); end
    run_op(32'hFFFFFFFF, 32'd16, 1'b0, 1'b0, res, lat);
    checks++; if (res !== 32'h0FFFFFFF) begin errors++; $display("FAIL divu_max_16 got=%h exp=0fffffff", res); end
  endtask

  task automatic test_signed();
    logic [31:0] res;
    int lat;
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, res, lat);
    checks++; if (res !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_m7_2 got=%h exp=fffffffd", res); end
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, res, lat);
    checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_m7_2 got=%h exp=ffffffff", res); end
    run_op(32'd7, 32'hFFFFFFFE, 1'b1, 1'b1, res, lat);
    checks++; if (res !== 32'h00000001) begin errors++; $display("FAIL rem_7_m2 got=%h exp=00000001", res); end
    run_op(32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, res, lat);
    checks++; if (res !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_7_m2 got=%h exp=fffffffd", res); end
    run_op(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 1'b0, res, lat);
    checks++; if (res !== 32'h00000003) begin errors++; $display("FAIL div_m7_m2 got=%h exp=00000003", res); end
  endtask

  task automatic test_div_zero();
    logic [31:0] res;
    int lat;
    run_op(32'h12345678, 32'h0, 1'b0, 1'b0, res, lat);
    checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu_zero got=%h exp=ffffffff", res); end
    checks++; if (lat !== ZERO_LAT) begin errors++; $display("FAIL divu_zero_latency got=%0d exp=%0d", lat, ZERO_LAT); end
    run_op(32'h12345678, 32'h0, 1'b0, 1'b1, res, lat);
    checks++; if (res !== 32'h12345678) begin errors++; $display("FAIL remu_zero got=%h exp=12345678", res); end
    run_op(32'h12345678, 32'h0, 1'b1, 1'b0, res, lat);
    checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_zero got=%h exp=ffffffff", res); end
    checks++; if (lat !== ZERO_LAT) begin errors++; $display("FAIL div_zero_latency got=%0d exp=%0d", lat, ZERO_LAT); end
    run_op(32'h12345678, 32'h0, 1'b1, 1'b1, res, lat);
    checks++; if (res !== 32'h12345678) begin errors++; $display("FAIL rem_zero got=%h exp=12345678", res); end
    run_op(32'hFFFFFFF9, 32'h0, 1'b1, 1'b0, res, lat);
    checks++; if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_zero got=%h exp=ffffffff", res); end
    run_op(32'hFFFFFFF9, 32'h0, 1'b1, 1'b1, res, lat);
    checks++; if (res !== 32'hFFFFFFF9) begin errors++; $display("FAIL rem_neg_zero got=%h exp=fffffff9", res); end
  endtask

  task automatic test_overflow();
    logic [31:0] res;
    int lat;
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, res, lat);
    checks++; if (res !== 32'h80000000) begin errors++; $display("FAIL div_overflow got=%h exp=80000000", res); end
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, res, lat);
    checks++; if (res !== 32'h00000000) begin errors++; $display("FAIL rem_overflow got=%h exp=00000000", res); end
  endtask

  task automatic test_back_pressure();
    int lat;
    dividend = 32'd1000;
    divisor  = 32'd10;
    sgn      = 1'b0;
    rem_sel  = 1'b0;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    // Keep presenting a different operation while busy; it must not disturb the one in flight.
    dividend = 32'd5;
    divisor  = 32'd5;
    rem_sel  = 1'b1;
    lat = 0;
    while (valid_out !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1 lat++;
      valid_in = lat[0];
    end
    checks++; if (lat !== 33) begin errors++; $display("FAIL bp_latency got=%0d exp=33", lat); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL bp_valid cycle=%0d got=%b exp=1", i, valid_out); end
      checks++; if (result !== 32'd100) begin errors++; $display("FAIL bp_result cycle=%0d got=%h exp=00000064", i, result); end
      checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL bp_ready cycle=%0d got=%b exp=0", i, ready_out); end
      valid_in = ~valid_in;
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(posedge clk);
    #1 ready_in = 1'b0;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL bp_retire_valid got=%b exp=0", valid_out); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL bp_retire_ready got=%b exp=1", ready_out); end
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] res;
    int lat;
    int seen;
    dividend = 32'd1000;
    divisor  = 32'd3;
    sgn      = 1'b0;
    rem_sel  = 1'b0;
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got=%b exp=1", ready_out); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got=%b exp=0", valid_out); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL mid_reset_result got=%h exp=0", result); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (valid_out === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_reset_no_valid got=%0d exp=0", seen); end
    run_op(32'd9, 32'd3, 1'b0, 1'b0, res, lat);
    checks++; if (res !== 32'd3) begin errors++; $display("FAIL divu_9_3 got=%h exp=00000003", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_9_3_latency got=%0d exp=33", lat); end
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    ready_in = 1'b0;
    dividend = '0;
    divisor  = '0;
    sgn      = 1'b0;
    rem_sel  = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_pressure();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
